tpu_perf_monitor: RTL and testbench

//  Synthesisable performance monitor for tpu_core. Snoops start, feed handshake and done.

---
 rtl/tpu_perf_pkg.sv | 25 ++
 rtl/tpu_sat_counter.sv | 46 ++++
 rtl/tpu_perf_monitor.sv | 185 ++++++++++++++++++
 tb/tb_tpu_perf_monitor.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_perf_pkg.sv
// Shared types, default widths and saturating-increment helper for the tpu_core perf monitor.
package tpu_perf_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int unsigned DEF_CNT_W = 32;
    localparam int unsigned DEF_MAC_W = 40;
    localparam int unsigned DEF_RUN_W = 16;

    // Add step to value, clipping at the all-ones value of a width-bit counter.
    function automatic logic [63:0] sat_inc(input logic [63:0]   value,
                                            input logic [63:0]   step,
                                            input int unsigned   width);
        logic [63:0] max_v;
        max_v = (width >= 64) ? '1 : ((64'(1) << width) - 64'(1));
        if ((value >= max_v) || (step > (max_v - value))) begin
            return max_v;
        end
        return value + step;
    endfunction

endpackage

// File: rtl/tpu_sat_counter.sv
// Saturating up-counter with a sticky flag that records any clipped increment.
module tpu_sat_counter
    import tpu_perf_pkg::*;
#(
    parameter int unsigned W    = 32,
    parameter int unsigned STEP = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] value,
    output logic         sat,
    output logic [W-1:0] value_nxt_c,
    output logic         sat_nxt_c
);

    logic [63:0] sum;
    logic [63:0] stepped;

    // Next value is exported so the owner can snapshot this cycle's increment.
    always_comb begin
        value_nxt_c = value;
        sat_nxt_c   = sat;
        sum         = 64'(value) + 64'(STEP);
        stepped     = sat_inc(64'(value), 64'(STEP), W);
        if (clr) begin
            value_nxt_c = '0;
            sat_nxt_c   = 1'b0;
        end else if (inc) begin
            value_nxt_c = W'(stepped);
            sat_nxt_c   = sat | (stepped != sum);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
            sat   <= 1'b0;
        end else begin
            value <= value_nxt_c;
            sat   <= sat_nxt_c;
        end
    end

endmodule

// File: rtl/tpu_perf_monitor.sv
// Run-level performance monitor snooping tpu_core start/feed/done into registered snapshots.
// Optional watchdog enabled by defining TPU_PERF_WATCHDOG_EN.
module tpu_perf_monitor
    import tpu_perf_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned CNT_W = DEF_CNT_W,
    parameter int unsigned MAC_W = DEF_MAC_W,
    parameter int unsigned RUN_W = DEF_RUN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             start,
    input  logic             in_valid,
    input  logic             in_ready,
    input  logic             done,
    input  logic [CNT_W-1:0] cfg_timeout,
    output logic             active,
    output logic             perf_valid,
    output logic             timeout,
    output logic             overflow,
    output logic [CNT_W-1:0] cyc_total,
    output logic [CNT_W-1:0] cyc_feed,
    output logic [CNT_W-1:0] cyc_stall,
    output logic [CNT_W-1:0] cyc_bubble,
    output logic [MAC_W-1:0] mac_count,
    output logic [RUN_W-1:0] run_count
);

    localparam int unsigned MAC_STEP = N * N;

    state_e state;
    state_e nxt_state;

    logic cnt_clr;
    logic cnt_run;
    logic feed_inc;
    logic stall_inc;
    logic bubble_inc;
    logic wd_hit;
    logic snap_en;
    logic snap_timeout;
    logic run_inc;
    logic flags_drop;
    logic ovf_nxt;

    logic [CNT_W-1:0] tot_q,    tot_nxt;
    logic [CNT_W-1:0] feed_q,   feed_nxt;
    logic [CNT_W-1:0] stall_q,  stall_nxt;
    logic [CNT_W-1:0] bubble_q, bubble_nxt;
    logic [MAC_W-1:0] mac_q,    mac_nxt;
    logic             tot_sat,    tot_sat_nxt;
    logic             feed_sat,   feed_sat_nxt;
    logic             stall_sat,  stall_sat_nxt;
    logic             bubble_sat, bubble_sat_nxt;
    logic             mac_sat,    mac_sat_nxt;

    // Counter controls kept outside the FSM process so the watchdog compare has no loop.
    assign cnt_clr    = clear | ((state == IDLE) & start);
    assign cnt_run    = (state == RUN) & ~clear;
    assign feed_inc   = cnt_run & in_valid & in_ready;
    assign stall_inc  = cnt_run & in_valid & ~in_ready;
    assign bubble_inc = cnt_run & ~in_valid;

    tpu_sat_counter #(.W(CNT_W), .STEP(1)) u_total (
        .clk(clk), .rst(rst), .clr(cnt_clr), .inc(cnt_run),
        .value(tot_q), .sat(tot_sat), .value_nxt_c(tot_nxt), .sat_nxt_c(tot_sat_nxt)
    );

    tpu_sat_counter #(.W(CNT_W), .STEP(1)) u_feed (
        .clk(clk), .rst(rst), .clr(cnt_clr), .inc(feed_inc),
        .value(feed_q), .sat(feed_sat), .value_nxt_c(feed_nxt), .sat_nxt_c(feed_sat_nxt)
    );

    tpu_sat_counter #(.W(CNT_W), .STEP(1)) u_stall (
        .clk(clk), .rst(rst), .clr(cnt_clr), .inc(stall_inc),
        .value(stall_q), .sat(stall_sat), .value_nxt_c(stall_nxt), .sat_nxt_c(stall_sat_nxt)
    );

    tpu_sat_counter #(.W(CNT_W), .STEP(1)) u_bubble (
        .clk(clk), .rst(rst), .clr(cnt_clr), .inc(bubble_inc),
        .value(bubble_q), .sat(bubble_sat), .value_nxt_c(bubble_nxt), .sat_nxt_c(bubble_sat_nxt)
    );

    tpu_sat_counter #(.W(MAC_W), .STEP(MAC_STEP)) u_mac (
        .clk(clk), .rst(rst), .clr(cnt_clr), .inc(feed_inc),
        .value(mac_q), .sat(mac_sat), .value_nxt_c(mac_nxt), .sat_nxt_c(mac_sat_nxt)
    );

    assign ovf_nxt = tot_sat_nxt | feed_sat_nxt | stall_sat_nxt | bubble_sat_nxt | mac_sat_nxt;

    // Snapshots are taken from next values, so registered live state is only observed here.
    logic unused_live;
    assign unused_live = ^{tot_q, feed_q, stall_q, bubble_q, mac_q,
                           tot_sat, feed_sat, stall_sat, bubble_sat, mac_sat};

`ifdef TPU_PERF_WATCHDOG_EN
    assign wd_hit = (cfg_timeout != '0) && (tot_nxt == cfg_timeout);
`else
    logic unused_cfg;
    assign wd_hit     = 1'b0;
    assign unused_cfg = ^cfg_timeout;
`endif

    // Next-state and snapshot control; clear outranks done/watchdog, which outrank start.
    always_comb begin
        nxt_state    = state;
        snap_en      = 1'b0;
        snap_timeout = 1'b0;
        run_inc      = 1'b0;
        flags_drop   = 1'b0;
        if (clear) begin
            nxt_state = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        nxt_state  = RUN;
                        flags_drop = 1'b1;
                    end
                end
                RUN: begin
                    if (done) begin
                        nxt_state = IDLE;
                        snap_en   = 1'b1;
                        run_inc   = 1'b1;
                    end else if (wd_hit) begin
                        nxt_state    = IDLE;
                        snap_en      = 1'b1;
                        snap_timeout = 1'b1;
                    end
                end
                default: nxt_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            active     <= 1'b0;
            perf_valid <= 1'b0;
            timeout    <= 1'b0;
            overflow   <= 1'b0;
            cyc_total  <= '0;
            cyc_feed   <= '0;
            cyc_stall  <= '0;
            cyc_bubble <= '0;
            mac_count  <= '0;
            run_count  <= '0;
        end else begin
            state  <= nxt_state;
            active <= (state == RUN);
            if (clear) begin
                perf_valid <= 1'b0;
                timeout    <= 1'b0;
                overflow   <= 1'b0;
                cyc_total  <= '0;
                cyc_feed   <= '0;
                cyc_stall  <= '0;
                cyc_bubble <= '0;
                mac_count  <= '0;
                run_count  <= '0;
            end else if (snap_en) begin
                perf_valid <= 1'b1;
                timeout    <= snap_timeout;
                overflow   <= ovf_nxt;
                cyc_total  <= tot_nxt;
                cyc_feed   <= feed_nxt;
                cyc_stall  <= stall_nxt;
                cyc_bubble <= bubble_nxt;
                mac_count  <= mac_nxt;
                if (run_inc) begin
                    run_count <= RUN_W'(sat_inc(64'(run_count), 64'd1, RUN_W));
                end
            end else if (flags_drop) begin
                perf_valid <= 1'b0;
                timeout    <= 1'b0;
                overflow   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tpu_perf_monitor.sv
// Directed bench for tpu_perf_monitor: a default instance plus a 4-bit counter instance.
module tb_tpu_perf_monitor;

    logic        clk = 1'b0;
    logic        rst, clear, start, in_valid, in_ready, done;
    logic [31:0] cfg_timeout;

    logic        active, perf_valid, timeout, overflow;
    logic [31:0] cyc_total, cyc_feed, cyc_stall, cyc_bubble;
    logic [39:0] mac_count;
    logic [15:0] run_count;

    logic        s_active, s_perf_valid, s_timeout, s_overflow;
    logic [3:0]  s_cyc_total, s_cyc_feed, s_cyc_stall, s_cyc_bubble;
    logic [39:0] s_mac_count;
    logic [15:0] s_run_count;

    int total_checks = 0;
    int bad = 0;

    always #5 clk = ~clk;

    tpu_perf_monitor #(.N(4)) dut (
        .clk(clk), .rst(rst), .clear(clear), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .done(done),
        .cfg_timeout(cfg_timeout),
        .active(active), .perf_valid(perf_valid), .timeout(timeout), .overflow(overflow),
        .cyc_total(cyc_total), .cyc_feed(cyc_feed), .cyc_stall(cyc_stall),
        .cyc_bubble(cyc_bubble), .mac_count(mac_count), .run_count(run_count)
    );

    tpu_perf_monitor #(.N(4), .CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .clear(clear), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .done(done),
        .cfg_timeout(cfg_timeout[3:0]),
        .active(s_active), .perf_valid(s_perf_valid), .timeout(s_timeout), .overflow(s_overflow),
        .cyc_total(s_cyc_total), .cyc_feed(s_cyc_feed), .cyc_stall(s_cyc_stall),
        .cyc_bubble(s_cyc_bubble), .mac_count(s_mac_count), .run_count(s_run_count)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clear    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_ready = 1'b0;
        done     = 1'b0;
    endtask

    // start sampled at e0, mask bit i drives edge ei, done (optional) at e<len>.
    task automatic do_run(input logic [31:0] vmask, input logic [31:0] rmask,
                          input logic [31:0] smask, input int len, input bit with_done);
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 1; i <= len; i++) begin
            in_valid = vmask[i];
            in_ready = rmask[i];
            start    = smask[i];
            done     = with_done && (i == len);
            cyc();
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cfg_timeout = 32'd0;
        idle_inputs();
        repeat (3) cyc();
        total_checks++;
        if ({active, perf_valid, timeout, overflow} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags: got %b want 0000", {active, perf_valid, timeout, overflow});
        end
        total_checks++;
        if (cyc_total !== 32'd0 || mac_count !== 40'd0) begin
            bad++; $display("FAIL reset_counts: got total=%0d mac=%0d want 0 0", cyc_total, mac_count);
        end
        total_checks++;
        if (run_count !== 16'd0) begin
            bad++; $display("FAIL reset_runs: got %0d want 0", run_count);
        end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_basic();
        do_run(32'h1E, 32'h1E, 32'h0, 10, 1'b1);
        total_checks++;
        if ({cyc_total, cyc_feed, cyc_stall, cyc_bubble} !== {32'd10, 32'd4, 32'd0, 32'd6}) begin
            bad++; $display("FAIL basic_counts: got %0d/%0d/%0d/%0d want 10/4/0/6",
                            cyc_total, cyc_feed, cyc_stall, cyc_bubble);
        end
        total_checks++;
        if (mac_count !== 40'd64) begin
            bad++; $display("FAIL basic_mac: got %0d want 64", mac_count);
        end
        total_checks++;
        if (run_count !== 16'd1 || perf_valid !== 1'b1 || timeout !== 1'b0 || overflow !== 1'b0) begin
            bad++; $display("FAIL basic_status: got runs=%0d pv=%b to=%b ov=%b want 1 1 0 0",
                            run_count, perf_valid, timeout, overflow);
        end
        total_checks++;
        if (active !== 1'b1) begin
            bad++; $display("FAIL basic_active_done: got %b want 1", active);
        end
        cyc();
        total_checks++;
        if (active !== 1'b0 || perf_valid !== 1'b1) begin
            bad++; $display("FAIL basic_after: got active=%b pv=%b want 0 1", active, perf_valid);
        end
    endtask

    task automatic test_backpressure();
        do_run(32'h7E, 32'h72, 32'h0, 10, 1'b1);
        total_checks++;
        if ({cyc_total, cyc_feed, cyc_stall, cyc_bubble} !== {32'd10, 32'd4, 32'd2, 32'd4}) begin
            bad++; $display("FAIL bp_counts: got %0d/%0d/%0d/%0d want 10/4/2/4",
                            cyc_total, cyc_feed, cyc_stall, cyc_bubble);
        end
        total_checks++;
        if (mac_count !== 40'd64 || run_count !== 16'd2) begin
            bad++; $display("FAIL bp_mac_runs: got mac=%0d runs=%0d want 64 2", mac_count, run_count);
        end
    endtask

    task automatic test_start_in_run();
        do_run(32'h1E, 32'h1E, 32'h28, 10, 1'b1);
        total_checks++;
        if ({cyc_total, cyc_feed, cyc_bubble} !== {32'd10, 32'd4, 32'd6} || run_count !== 16'd3) begin
            bad++; $display("FAIL restart_counts: got %0d/%0d/%0d runs=%0d want 10/4/6 runs=3",
                            cyc_total, cyc_feed, cyc_bubble, run_count);
        end
    endtask

    task automatic test_done_idle();
        done = 1'b1;
        cyc();
        done = 1'b0;
        cyc();
        total_checks++;
        if (run_count !== 16'd3 || cyc_total !== 32'd10 || perf_valid !== 1'b1) begin
            bad++; $display("FAIL done_idle: got runs=%0d total=%0d pv=%b want 3 10 1",
                            run_count, cyc_total, perf_valid);
        end
    endtask

    task automatic test_clear_done();
        start = 1'b1;
        cyc();
        start    = 1'b0;
        in_valid = 1'b1;
        in_ready = 1'b1;
        repeat (3) cyc();
        clear = 1'b1;
        done  = 1'b1;
        cyc();
        idle_inputs();
        total_checks++;
        if (perf_valid !== 1'b0 || run_count !== 16'd0) begin
            bad++; $display("FAIL clear_done: got pv=%b runs=%0d want 0 0", perf_valid, run_count);
        end
        total_checks++;
        if (cyc_total !== 32'd0 || mac_count !== 40'd0) begin
            bad++; $display("FAIL clear_snap: got total=%0d mac=%0d want 0 0", cyc_total, mac_count);
        end
        cyc();
        total_checks++;
        if (active !== 1'b0) begin
            bad++; $display("FAIL clear_active: got %b want 0", active);
        end
    endtask

    task automatic test_saturation();
        do_run(32'h0, 32'h0, 32'h0, 20, 1'b1);
        total_checks++;
        if (s_cyc_total !== 4'd15 || s_cyc_bubble !== 4'd15 || s_overflow !== 1'b1) begin
            bad++; $display("FAIL sat_small: got total=%0d bubble=%0d ov=%b want 15 15 1",
                            s_cyc_total, s_cyc_bubble, s_overflow);
        end
        total_checks++;
        if (cyc_total !== 32'd20 || overflow !== 1'b0 || run_count !== 16'd1) begin
            bad++; $display("FAIL sat_wide: got total=%0d ov=%b runs=%0d want 20 0 1",
                            cyc_total, overflow, run_count);
        end
        do_run(32'h1E, 32'h1E, 32'h0, 10, 1'b1);
        total_checks++;
        if (s_cyc_total !== 4'd10 || s_cyc_feed !== 4'd4 || s_overflow !== 1'b0) begin
            bad++; $display("FAIL sat_clean: got total=%0d feed=%0d ov=%b want 10 4 0",
                            s_cyc_total, s_cyc_feed, s_overflow);
        end
    endtask

    task automatic test_watchdog();
`ifdef TPU_PERF_WATCHDOG_EN
        cfg_timeout = 32'd8;
        do_run(32'h0, 32'h0, 32'h0, 8, 1'b0);
        total_checks++;
        if (timeout !== 1'b1 || perf_valid !== 1'b1 || cyc_total !== 32'd8 || run_count !== 16'd2) begin
            bad++; $display("FAIL wd_fire: got to=%b pv=%b total=%0d runs=%0d want 1 1 8 2",
                            timeout, perf_valid, cyc_total, run_count);
        end
        repeat (2) cyc();
        total_checks++;
        if (active !== 1'b0 || s_timeout !== 1'b1 || s_cyc_total !== 4'd8) begin
            bad++; $display("FAIL wd_idle: got active=%b s_to=%b s_total=%0d want 0 1 8",
                            active, s_timeout, s_cyc_total);
        end
        do_run(32'h0, 32'h0, 32'h0, 8, 1'b1);
        total_checks++;
        if (timeout !== 1'b0 || cyc_total !== 32'd8 || run_count !== 16'd3) begin
            bad++; $display("FAIL wd_done_wins: got to=%b total=%0d runs=%0d want 0 8 3",
                            timeout, cyc_total, run_count);
        end
        cfg_timeout = 32'd0;
`else
        do_run(32'h0, 32'h0, 32'h0, 12, 1'b1);
        total_checks++;
        if (timeout !== 1'b0 || cyc_total !== 32'd12 || run_count !== 16'd3) begin
            bad++; $display("FAIL no_wd: got to=%b total=%0d runs=%0d want 0 12 3",
                            timeout, cyc_total, run_count);
        end
`endif
    endtask

    task automatic test_reset_mid();
        start = 1'b1;
        cyc();
        start    = 1'b0;
        in_valid = 1'b1;
        in_ready = 1'b1;
        repeat (2) cyc();
        in_valid = 1'b0;
        in_ready = 1'b0;
        repeat (2) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        total_checks++;
        if ({active, perf_valid, timeout, overflow} !== 4'b0000 || run_count !== 16'd0
            || cyc_total !== 32'd0) begin
            bad++; $display("FAIL rst_mid: got flags=%b runs=%0d total=%0d want 0000 0 0",
                            {active, perf_valid, timeout, overflow}, run_count, cyc_total);
        end
        do_run(32'h1E, 32'h1E, 32'h0, 10, 1'b1);
        total_checks++;
        if ({cyc_total, cyc_feed, cyc_bubble} !== {32'd10, 32'd4, 32'd6} || mac_count !== 40'd64
            || run_count !== 16'd1) begin
            bad++; $display("FAIL rst_rerun: got %0d/%0d/%0d mac=%0d runs=%0d want 10/4/6 64 1",
                            cyc_total, cyc_feed, cyc_bubble, mac_count, run_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_start_in_run();
        test_done_idle();
        test_clear_done();
        test_saturation();
        test_watchdog();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total_checks, bad);
        $finish;
    end

endmodule
